// File: rtl/l2_lookup_ctrl_pkg.sv
// rtl/l2_lookup_ctrl_pkg.sv - shared types and constants for the L2 lookup sequencer
package l2_lookup_ctrl_pkg;

  localparam int L2_SET_BITS = 8;

  typedef logic [L2_SET_BITS-1:0] l2_set_t;

  localparam logic L2_LOOKUP     = 1'b0;
  localparam logic L2_LOOKUP_FWD = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_RESP   = 2'd2
  } l2_lookup_ctrl_state_t;

endpackage

// File: rtl/l2_lookup_ctrl.sv
// rtl/l2_lookup_ctrl.sv - arbitrates CPU requests and LLC forwards onto the L2 tag/state lookup path
module l2_lookup_ctrl
  import l2_lookup_ctrl_pkg::*;
#(
  parameter int SET_BITS   = L2_SET_BITS,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                l2_req_valid,
  input  logic [SET_BITS-1:0] l2_req_set,
  output logic                l2_req_ready,
  input  logic                l2_fwd_valid,
  input  logic [SET_BITS-1:0] l2_fwd_set,
  output logic                l2_fwd_ready,
  input  logic                stall,
  output logic                rd_en,
  output logic [SET_BITS-1:0] rd_set,
  output logic                lookup_en,
  output logic                lookup_mode,
  output logic                done_valid,
  output logic                done_fwd,
  output logic [SET_BITS-1:0] done_set,
  input  logic                done_ready
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  l2_lookup_ctrl_state_t state_q, state_d;
  logic [3:0]            starve_cnt_q, starve_cnt_d;
  logic                  mode_q, mode_d;
  logic [SET_BITS-1:0]   set_q, set_d;
  logic                  req_win, fwd_win, grant;

  always_comb begin
    req_win      = 1'b0;
    fwd_win      = 1'b0;
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    mode_d       = mode_q;
    set_d        = set_q;

    // Grants are also held off while reset is asserted so every output reads 0.
    if (state_q == ST_IDLE && !stall && rst) begin
      req_win = l2_req_valid && (!l2_fwd_valid || starve_cnt_q == STARVE_LIM);
      fwd_win = l2_fwd_valid && !req_win;
    end
    grant = req_win | fwd_win;

    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d = ST_LOOKUP;
          mode_d  = fwd_win ? L2_LOOKUP_FWD : L2_LOOKUP;
          set_d   = fwd_win ? l2_fwd_set : l2_req_set;
        end
        if (!l2_req_valid || req_win) begin
          starve_cnt_d = 4'd0;
        end else if (fwd_win && starve_cnt_q != STARVE_LIM) begin
          starve_cnt_d = starve_cnt_q + 4'd1;
        end
      end
      ST_LOOKUP: state_d = ST_RESP;
      ST_RESP: begin
        if (done_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= 4'd0;
      mode_q       <= L2_LOOKUP;
      set_q        <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      mode_q       <= mode_d;
      set_q        <= set_d;
    end
  end

  assign l2_req_ready = req_win;
  assign l2_fwd_ready = fwd_win;
  assign rd_en        = grant;
  assign rd_set       = fwd_win ? l2_fwd_set : (req_win ? l2_req_set : '0);
  assign lookup_en    = (state_q == ST_LOOKUP);
  assign lookup_mode  = mode_q;
  assign done_valid   = (state_q == ST_RESP);
  assign done_fwd     = done_valid & mode_q;
  assign done_set     = done_valid ? set_q : '0;

endmodule

// File: tb/tb_l2_lookup_ctrl.sv
// tb/tb_l2_lookup_ctrl.sv - directed bench for l2_lookup_ctrl
module tb_l2_lookup_ctrl;
  import l2_lookup_ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic       l2_req_valid, l2_fwd_valid, stall, done_ready;
  logic [7:0] l2_req_set, l2_fwd_set;
  logic       l2_req_ready, l2_fwd_ready, rd_en, lookup_en, lookup_mode;
  logic       done_valid, done_fwd;
  logic [7:0] rd_set, done_set;

  int pass_cnt  = 0;
  int total_cnt = 0;

  l2_lookup_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .l2_req_valid (l2_req_valid),
    .l2_req_set   (l2_req_set),
    .l2_req_ready (l2_req_ready),
    .l2_fwd_valid (l2_fwd_valid),
    .l2_fwd_set   (l2_fwd_set),
    .l2_fwd_ready (l2_fwd_ready),
    .stall        (stall),
    .rd_en        (rd_en),
    .rd_set       (rd_set),
    .lookup_en    (lookup_en),
    .lookup_mode  (lookup_mode),
    .done_valid   (done_valid),
    .done_fwd     (done_fwd),
    .done_set     (done_set),
    .done_ready   (done_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // From the negedge of a grant cycle: walk LOOKUP and RESP and handshake back to IDLE.
  task automatic finish_lookup(input bit drop);
    @(posedge clk); #1;
    if (drop) begin
      l2_req_valid = 1'b0;
      l2_fwd_valid = 1'b0;
    end
    @(posedge clk); #1 done_ready = 1'b1;
    @(posedge clk); #1 done_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; l2_req_valid = 1'b0; l2_fwd_valid = 1'b0; stall = 1'b0; done_ready = 1'b0;
    l2_req_set = 8'h00; l2_fwd_set = 8'h00;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({l2_req_ready, l2_fwd_ready, rd_en, lookup_en, lookup_mode, done_valid, done_fwd} !== 7'b0)
      $display("FAIL reset_ctrl_outputs got=%b want=0000000",
               {l2_req_ready, l2_fwd_ready, rd_en, lookup_en, lookup_mode, done_valid, done_fwd});
    else pass_cnt++;
    total_cnt++;
    if (rd_set !== 8'h00 || done_set !== 8'h00)
      $display("FAIL reset_sets rd_set=%h done_set=%h want 00/00", rd_set, done_set);
    else pass_cnt++;
    total_cnt++;
    if (dut.starve_cnt_q !== 4'd0)
      $display("FAIL reset_starve_cnt got=%0d want=0", dut.starve_cnt_q);
    else pass_cnt++;
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_req_only(input logic [7:0] set);
    l2_req_valid = 1'b1; l2_req_set = set;
    @(negedge clk);
    total_cnt++;
    if (l2_req_ready !== 1'b1 || l2_fwd_ready !== 1'b0 || rd_en !== 1'b1 || rd_set !== set)
      $display("FAIL req_grant ready=%b fwd_ready=%b rd_en=%b rd_set=%h want 1/0/1/%h",
               l2_req_ready, l2_fwd_ready, rd_en, rd_set, set);
    else pass_cnt++;
    @(posedge clk); #1 l2_req_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (lookup_en !== 1'b1 || lookup_mode !== L2_LOOKUP || done_valid !== 1'b0 || l2_req_ready !== 1'b0)
      $display("FAIL req_lookup lookup_en=%b mode=%b done_valid=%b ready=%b want 1/0/0/0",
               lookup_en, lookup_mode, done_valid, l2_req_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done_valid !== 1'b1 || done_fwd !== 1'b0 || done_set !== set || lookup_en !== 1'b0)
      $display("FAIL req_done valid=%b fwd=%b set=%h lookup_en=%b want 1/0/%h/0",
               done_valid, done_fwd, done_set, lookup_en, set);
    else pass_cnt++;
    @(posedge clk); #1 done_ready = 1'b1;
    @(posedge clk); #1 done_ready = 1'b0;
  endtask

  task automatic test_both_valid;
    l2_req_valid = 1'b1; l2_req_set = 8'h56;
    l2_fwd_valid = 1'b1; l2_fwd_set = 8'h34;
    @(negedge clk);
    total_cnt++;
    if (l2_fwd_ready !== 1'b1 || l2_req_ready !== 1'b0 || rd_set !== 8'h34)
      $display("FAIL both_fwd_wins fwd_ready=%b req_ready=%b rd_set=%h want 1/0/34",
               l2_fwd_ready, l2_req_ready, rd_set);
    else pass_cnt++;
    @(posedge clk); #1 l2_fwd_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (lookup_en !== 1'b1 || lookup_mode !== L2_LOOKUP_FWD)
      $display("FAIL both_fwd_mode lookup_en=%b mode=%b want 1/1", lookup_en, lookup_mode);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done_valid !== 1'b1 || done_fwd !== 1'b1 || done_set !== 8'h34)
      $display("FAIL both_fwd_done valid=%b fwd=%b set=%h want 1/1/34", done_valid, done_fwd, done_set);
    else pass_cnt++;
    @(posedge clk); #1 done_ready = 1'b1;
    @(posedge clk); #1 done_ready = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (l2_req_ready !== 1'b1 || l2_fwd_ready !== 1'b0 || rd_set !== 8'h56)
      $display("FAIL both_req_next req_ready=%b fwd_ready=%b rd_set=%h want 1/0/56",
               l2_req_ready, l2_fwd_ready, rd_set);
    else pass_cnt++;
    finish_lookup(1'b1);
  endtask

  task automatic test_starvation;
    l2_req_valid = 1'b1; l2_req_set = 8'h41;
    l2_fwd_valid = 1'b1; l2_fwd_set = 8'h40;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total_cnt++;
      if (l2_fwd_ready !== 1'b1 || l2_req_ready !== 1'b0)
        $display("FAIL starve_fwd_grant%0d fwd_ready=%b req_ready=%b want 1/0", i, l2_fwd_ready, l2_req_ready);
      else pass_cnt++;
      finish_lookup(1'b0);
    end
    @(negedge clk);
    total_cnt++;
    if (l2_req_ready !== 1'b1 || l2_fwd_ready !== 1'b0 || rd_set !== 8'h41)
      $display("FAIL starve_req_grant req_ready=%b fwd_ready=%b rd_set=%h want 1/0/41",
               l2_req_ready, l2_fwd_ready, rd_set);
    else pass_cnt++;
    @(posedge clk); #1 l2_req_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (dut.starve_cnt_q !== 4'd0)
      $display("FAIL starve_cnt_clear got=%0d want=0", dut.starve_cnt_q);
    else pass_cnt++;
    @(posedge clk); #1 done_ready = 1'b1;
    @(posedge clk); #1 done_ready = 1'b0; l2_req_valid = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (l2_fwd_ready !== 1'b1 || l2_req_ready !== 1'b0)
      $display("FAIL starve_fwd_after_clear fwd_ready=%b req_ready=%b want 1/0", l2_fwd_ready, l2_req_ready);
    else pass_cnt++;
    finish_lookup(1'b1);
  endtask

  task automatic test_done_hold;
    l2_req_valid = 1'b1; l2_req_set = 8'h77;
    @(negedge clk);
    total_cnt++;
    if (rd_en !== 1'b1 || l2_req_ready !== 1'b1)
      $display("FAIL hold_grant rd_en=%b ready=%b want 1/1", rd_en, l2_req_ready);
    else pass_cnt++;
    @(posedge clk); #1 l2_req_valid = 1'b0; l2_fwd_valid = 1'b1; l2_fwd_set = 8'h88;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total_cnt++;
      if (done_valid !== 1'b1 || done_fwd !== 1'b0 || done_set !== 8'h77 || lookup_en !== 1'b0 ||
          rd_en !== 1'b0 || l2_fwd_ready !== 1'b0)
        $display("FAIL hold_wait%0d valid=%b fwd=%b set=%h lookup_en=%b rd_en=%b fwd_ready=%b want 1/0/77/0/0/0",
                 i, done_valid, done_fwd, done_set, lookup_en, rd_en, l2_fwd_ready);
      else pass_cnt++;
    end
    @(posedge clk); #1 done_ready = 1'b1;
    @(posedge clk); #1 done_ready = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (done_valid !== 1'b0 || l2_fwd_ready !== 1'b1 || rd_set !== 8'h88)
      $display("FAIL hold_release done_valid=%b fwd_ready=%b rd_set=%h want 0/1/88",
               done_valid, l2_fwd_ready, rd_set);
    else pass_cnt++;
    finish_lookup(1'b1);
  endtask

  task automatic test_stall;
    stall = 1'b1;
    l2_req_valid = 1'b1; l2_req_set = 8'h21;
    l2_fwd_valid = 1'b1; l2_fwd_set = 8'h22;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if (l2_req_ready !== 1'b0 || l2_fwd_ready !== 1'b0 || rd_en !== 1'b0)
        $display("FAIL stall_block%0d req_ready=%b fwd_ready=%b rd_en=%b want 0/0/0",
                 i, l2_req_ready, l2_fwd_ready, rd_en);
      else pass_cnt++;
    end
    @(posedge clk); #1 stall = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (l2_fwd_ready !== 1'b1 || rd_en !== 1'b1 || rd_set !== 8'h22)
      $display("FAIL stall_release fwd_ready=%b rd_en=%b rd_set=%h want 1/1/22", l2_fwd_ready, rd_en, rd_set);
    else pass_cnt++;
    finish_lookup(1'b1);
  endtask

  task automatic test_reset_mid;
    l2_req_valid = 1'b1; l2_req_set = 8'h5a;
    @(negedge clk);
    @(posedge clk); #1 l2_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (done_valid !== 1'b1 || done_set !== 8'h5a)
      $display("FAIL rstmid_in_resp valid=%b set=%h want 1/5a", done_valid, done_set);
    else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    total_cnt++;
    if ({done_valid, done_fwd, lookup_en, lookup_mode, rd_en, l2_req_ready, l2_fwd_ready} !== 7'b0 ||
        done_set !== 8'h00 || rd_set !== 8'h00)
      $display("FAIL rstmid_outputs ctrl=%b done_set=%h rd_set=%h want 0000000/00/00",
               {done_valid, done_fwd, lookup_en, lookup_mode, rd_en, l2_req_ready, l2_fwd_ready},
               done_set, rd_set);
    else pass_cnt++;
    total_cnt++;
    if (dut.state_q !== ST_IDLE || dut.starve_cnt_q !== 4'd0)
      $display("FAIL rstmid_state state=%0d cnt=%0d want 0/0", dut.state_q, dut.starve_cnt_q);
    else pass_cnt++;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (lookup_en !== 1'b0 || done_valid !== 1'b0)
      $display("FAIL rstmid_no_lookup lookup_en=%b done_valid=%b want 0/0", lookup_en, done_valid);
    else pass_cnt++;
    @(posedge clk); #1;
    test_req_only(8'h3c);
  endtask

  initial begin
    test_reset();
    test_req_only(8'h12);
    test_both_valid();
    test_starvation();
    test_done_hold();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/l2_lookup_ctrl.md
# l2_lookup_ctrl

Sequences the L2 tag/state lookup path, sharing it between two requesters: CPU-side requests and LLC-side forwards. Grants one requester, issues the tag/state SRAM read, pulses `lookup_en` with the matching `lookup_mode` one cycle later, then holds a done handshake toward the L2 main FSM while the lookup module's registered hit/empty/word-mask outputs stay stable. Forwards normally win; a starvation counter guarantees request progress.

## Interface
- `SET_BITS`, default 8: set index width, equal to the `l2_set_t` width.
- `STARVE_MAX`, default 4: consecutive forward grants allowed while a request waits; must be 1..15.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `l2_req_valid`  in  1  CPU request pending.
- `l2_req_set`  in  SET_BITS  set index of the request.
- `l2_req_ready`  out  1  request accepted this cycle when high with valid.
- `l2_fwd_valid`  in  1  forward pending.
- `l2_fwd_set`  in  SET_BITS  set index of the forward.
- `l2_fwd_ready`  out  1  forward accepted this cycle when high with valid.
- `stall`  in  1  blocks new grants, e.g. during eviction or fill.
- `rd_en`  out  1  tag/state SRAM read strobe; data is valid the next cycle.
- `rd_set`  out  SET_BITS  SRAM read index.
- `lookup_en`  out  1  one-cycle trigger to the lookup module.
- `lookup_mode`  out  1  `L2_LOOKUP` (0) for a request, `L2_LOOKUP_FWD` (1) for a forward.
- `done_valid`  out  1  lookup result registered and stable.
- `done_fwd`  out  1  result belongs to a forward (1) or a request (0).
- `done_set`  out  SET_BITS  set of the completed lookup.
- `done_ready`  in  1  main FSM consumes the result.

## Operation
- Three-state FSM: IDLE, LOOKUP, RESP.
- IDLE:
  - If `stall` is low and either valid is high, grant one requester.
  - Assert only the winner's ready, combinationally.
  - Drive `rd_en`=1 and `rd_set` from the winner's set.
  - Latch the winner's mode and set, then go to LOOKUP.
  - If `stall` is high, or neither valid is high: no ready, no `rd_en`.
- LOOKUP: `lookup_en`=1, `lookup_mode` from the latched mode; go to RESP unconditionally.
- RESP:
  - `done_valid`=1, with `done_fwd` and `done_set` from the latched values.
  - Return to IDLE when `done_ready` is high.
  - `lookup_en` stays 0, so the lookup module's registered outputs hold.
- Arbitration:
  - Forward wins by default.
  - `starve_cnt` (4 bits) increments on every forward grant made while `l2_req_valid` is high.
  - `starve_cnt` clears on a request grant, or when `l2_req_valid` is low in IDLE.
  - When `starve_cnt` equals `STARVE_MAX`, the request wins over a pending forward.
  - `starve_cnt` saturates at `STARVE_MAX` and never wraps.
- A lone valid requester always wins, regardless of `starve_cnt`.
- `lookup_mode` holds its last latched value outside LOOKUP; it is don't-care whenever `lookup_en` is low.

## Timing
- Reset:
  - FSM goes to IDLE; `starve_cnt`, latched mode and latched set clear to 0.
  - Every output is 0; `rd_set` and `done_set` are 0.
- Grant at cycle T (ready and valid both high, `rd_en` high) -> `lookup_en` at T+1 -> `done_valid` from T+2.
- Earliest next grant is the cycle after the done handshake, giving a minimum of 3 cycles per lookup.
- The done handshake is completed by `done_valid` and `done_ready` both high.
- `done_valid`, `done_fwd` and `done_set` are stable while waiting; `done_valid` never drops without a handshake.
- Ready signals are 0 outside IDLE. Requesters must hold valid and set until their ready is seen.
- `stall` is sampled only in IDLE; `stall` rising in LOOKUP or RESP does not abort the lookup in flight.
- Reset asserted mid-operation returns to IDLE immediately. A result not yet handshaken is dropped, and no `lookup_en` is issued afterward.
- Valid and `stall` rising in the same IDLE cycle: no grant.

## Structure
- Shared package/header:
  - `L2_LOOKUP` and `L2_LOOKUP_FWD` mode constants.
  - `l2_set_t`.
  - The FSM state enum `l2_lookup_ctrl_state_t`.
- Single module with no sub-modules.
- Sits beside the lookup module in the L2 top:
  - Its `lookup_en`/`lookup_mode` drive the lookup module.
  - Its `rd_en`/`rd_set` drive the tag/state buffer read.

## Test plan
- Request only, set 0x12: ready at T, `rd_en`=1 with `rd_set`=0x12 at T, `lookup_en`=1 with mode 0 at T+1, `done_valid`=1 with `done_fwd`=0 and `done_set`=0x12 at T+2.
- Request and forward valid together, `starve_cnt` 0: forward granted, `lookup_mode`=1; request granted on the next IDLE cycle.
- Forward held continuously, request waiting, `STARVE_MAX`=4: 4 forward grants, then the 5th grant goes to the request; `starve_cnt` returns to 0.
- `done_ready` held low for 5 cycles: `done_valid` stays 1 with constant set/fwd, `lookup_en` stays 0, no new grant; IDLE one cycle after `done_ready`=1.
- `stall`=1 with both valid high: no ready, no `rd_en` for 3 cycles; grant in the first cycle `stall`=0.
- `rst` asserted low during RESP: all outputs 0 asynchronously, FSM in IDLE, counter 0; after release, the next request gets normal T/T+1/T+2 timing.
